parity_stream_gen_chk: RTL and testbench

- Parametrised streaming parity block. Successor to the fixed 8-bit odd-parity generator.
- Two modes:
  - Generate: appends a per-word parity bit.
  - Check: validates a received parity bit.
- Odd/even parity is runtime-selectable. Tracks parity across multi-beat frames and counts parity errors.
- Sits between a byte/word source and the serial link framer (generate mode), or between the deframer and the consumer (check mode).

---
 rtl/parity_pkg.sv | 12 +
 rtl/parity_core.sv | 10 +
 rtl/parity_stream_gen_chk.sv | 111 +++++++++++
 tb/tb_parity_stream_gen_chk.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared mode constants and FSM state encoding for the parity stream block
package parity_pkg;
  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } state_t;
endpackage

// File: rtl/parity_core.sv
// rtl/parity_core.sv - combinational reduce-XOR parity with odd/even select
module parity_core #(
  parameter int W = 8
) (
  input  logic [W-1:0] data,
  input  logic         odd,
  output logic         par
);
  assign par = (^data) ^ odd;
endmodule

// File: rtl/parity_stream_gen_chk.sv
// rtl/parity_stream_gen_chk.sv - streaming parity generate/check with frame parity and error count
module parity_stream_gen_chk
  import parity_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 odd_sel,
  input  logic                 chk_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH:0]       in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       out_data,
  output logic                 out_last,
  output logic                 out_perr,
  output logic                 out_frame_par,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 clr_cnt
);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

  state_t state, state_next;
  logic   odd_lat, chk_lat, acc;
  logic   accept, first, eff_odd, eff_chk;
  logic   beat_par, rx_perr, data_par, acc_next;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign first    = (state == ST_IDLE);

  // The first beat of a frame uses the live mode inputs; later beats use the latched copy.
  assign eff_odd = first ? odd_sel  : odd_lat;
  assign eff_chk = first ? chk_mode : chk_lat;

  parity_core #(.W(WIDTH)) u_beat (
    .data (in_data[WIDTH-1:0]),
    .odd  (eff_odd),
    .par  (beat_par)
  );

  parity_core #(.W(WIDTH+1)) u_rx (
    .data (in_data),
    .odd  (eff_odd),
    .par  (rx_perr)
  );

  parity_core #(.W(WIDTH)) u_acc (
    .data (in_data[WIDTH-1:0]),
    .odd  (PAR_EVEN),
    .par  (data_par)
  );

  assign acc_next = (first ? 1'b0 : acc) ^ data_par;

  always_comb begin
    state_next = state;
    if (accept) begin
      case (state)
        ST_IDLE:     state_next = in_last ? ST_IDLE : ST_IN_FRAME;
        ST_IN_FRAME: state_next = in_last ? ST_IDLE : ST_IN_FRAME;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      odd_lat       <= PAR_EVEN;
      chk_lat       <= MODE_GEN;
      acc           <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      out_perr      <= 1'b0;
      out_frame_par <= 1'b0;
      err_cnt       <= '0;
    end else begin
      if (accept) begin
        if (first) begin
          odd_lat <= odd_sel;
          chk_lat <= chk_mode;
        end
        acc           <= in_last ? 1'b0 : acc_next;
        out_valid     <= 1'b1;
        out_data      <= (eff_chk == MODE_CHK) ? in_data : {beat_par, in_data[WIDTH-1:0]};
        out_last      <= in_last;
        out_perr      <= (eff_chk == MODE_CHK) & rx_perr;
        out_frame_par <= in_last & (acc_next ^ eff_odd);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Errors are counted when the beat is accepted, independent of output retirement.
      if (clr_cnt)
        err_cnt <= '0;
      else if (accept && (eff_chk == MODE_CHK) && rx_perr && (err_cnt != CNT_MAX))
        err_cnt <= err_cnt + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_parity_stream_gen_chk.sv
// tb/tb_parity_stream_gen_chk.sv - self-checking bench for parity_stream_gen_chk
module tb_parity_stream_gen_chk;
  logic       clk = 1'b0;
  logic       rst_n, odd_sel, chk_mode, in_valid, in_last, out_ready, clr_cnt;
  logic [8:0] in_data;
  logic       in_ready, out_valid, out_last, out_perr, out_frame_par;
  logic [8:0] out_data;
  logic [1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // behavioural model of the visible output state
  logic       m_valid, m_last, m_perr, m_fp;
  logic [8:0] m_data;
  int         m_cnt, m_ones;
  logic       m_in_frame, m_odd, m_chk;

  always #5 clk = ~clk;

  parity_stream_gen_chk #(.WIDTH(8), .ERR_CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .odd_sel(odd_sel), .chk_mode(chk_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_perr(out_perr), .out_frame_par(out_frame_par), .err_cnt(err_cnt), .clr_cnt(clr_cnt)
  );

  wire [14:0] dut_vec = {out_valid, out_data, out_last, out_perr, out_frame_par, err_cnt};
  wire [14:0] exp_vec = {m_valid, m_data, m_last, m_perr, m_fp, 2'(m_cnt)};
  wire        exp_rdy = !m_valid || out_ready;

  task automatic set_in(input logic v, input logic [8:0] d, input logic l,
                        input logic o, input logic c, input logic r);
    in_valid = v; in_data = d; in_last = l; odd_sel = o; chk_mode = c; out_ready = r;
    #1;
  endtask

  // Advance one clock, updating the model from the parity rules in arithmetic form.
  task automatic step();
    int o, c, n1, pe;
    pe = 0;
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_last = 0; m_perr = 0; m_fp = 0; m_cnt = 0;
      m_ones = 0; m_in_frame = 0; m_odd = 0; m_chk = 0;
    end else begin
      if (in_valid && exp_rdy) begin
        o = m_in_frame ? int'(m_odd) : int'(odd_sel);
        c = m_in_frame ? int'(m_chk) : int'(chk_mode);
        if (!m_in_frame) begin m_odd = odd_sel; m_chk = chk_mode; end
        n1 = (m_in_frame ? m_ones : 0) + $countones(in_data[7:0]);
        pe = (c != 0) ? ($countones(in_data) + o) % 2 : 0;
        m_data = (c != 0) ? in_data : {1'(($countones(in_data[7:0]) + o) % 2), in_data[7:0]};
        m_valid = 1; m_last = in_last; m_perr = (pe != 0);
        m_fp = in_last ? 1'((n1 + o) % 2) : 1'b0;
        m_ones = in_last ? 0 : n1;
        m_in_frame = !in_last;
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (clr_cnt) m_cnt = 0;
      else if (pe != 0 && m_cnt < 3) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; clr_cnt = 0;
    set_in(1, 9'h0ff, 0, 1, 1, 1);
    step();
    checks++;
    if (dut_vec !== 15'h0) begin errors++; $display("FAIL reset_state got %h want %h", dut_vec, 15'h0); end
    rst_n = 1;
  endtask

  task automatic test_gen_odd();
    set_in(1, 9'h000, 1, 1, 0, 1);
    step();
    checks++;
    if (dut_vec !== exp_vec) begin errors++; $display("FAIL gen_odd_model got %h want %h", dut_vec, exp_vec); end
    checks++;
    if ({out_valid, out_data, out_perr, out_frame_par} !== {1'b1, 9'h100, 1'b0, 1'b1}) begin
      errors++; $display("FAIL gen_odd_const got %b %h %b %b want 1 100 0 1", out_valid, out_data, out_perr, out_frame_par);
    end
    set_in(0, 9'h000, 0, 0, 0, 1);
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL gen_odd_one_cycle got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] beats [3] = '{9'h0a5, 9'h001, 9'h003};
    logic [8:0] want  [3] = '{9'h0a5, 9'h101, 9'h003};
    for (int i = 0; i < 3; i++) begin
      set_in(1, beats[i], 1, 0, 0, 1);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
      step();
      checks++;
      if (dut_vec !== exp_vec || out_data !== want[i] || out_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_beat[%0d] got %h data %h want %h data %h", i, dut_vec, out_data, exp_vec, want[i]);
      end
    end
  endtask

  task automatic test_check_odd();
    logic [8:0] beats [2] = '{9'h0a5, 9'h1a5};
    logic       perr  [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      set_in(1, beats[i], 1, 1, 1, 1);
      step();
      checks++;
      if (dut_vec !== exp_vec || out_perr !== perr[i] || err_cnt !== 2'd1) begin
        errors++; $display("FAIL check_odd[%0d] got %h perr %b cnt %0d want %h perr %b cnt 1", i, dut_vec, out_perr, err_cnt, exp_vec, perr[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [14:0] held;
    set_in(1, 9'h011, 1, 0, 0, 0);
    step();
    held = dut_vec;
    set_in(1, 9'h033, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0", i, in_ready); end
      step();
      checks++;
      if (dut_vec !== exp_vec || dut_vec !== held) begin
        errors++; $display("FAIL bp_hold[%0d] got %h want %h", i, dut_vec, exp_vec);
      end
    end
    set_in(1, 9'h033, 1, 1, 1, 1);
    step();
    checks++;
    if (dut_vec !== exp_vec || out_data !== 9'h033) begin errors++; $display("FAIL bp_release got %h want %h", dut_vec, exp_vec); end
  endtask

  task automatic test_frame();
    logic [8:0] beats [3] = '{9'h001, 9'h003, 9'h007};
    logic       osel  [3] = '{1'b1, 1'b0, 1'b0};
    logic [8:0] want  [3] = '{9'h001, 9'h103, 9'h007};
    for (int i = 0; i < 3; i++) begin
      set_in(1, beats[i], i == 2, osel[i], 0, 1);
      step();
      checks++;
      if (dut_vec !== exp_vec || out_data !== want[i] || out_frame_par !== (i == 2)) begin
        errors++; $display("FAIL frame[%0d] got %h fp %b want %h fp %0d", i, dut_vec, out_frame_par, exp_vec, i == 2);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 9'h000, 1, 1, 1, 1);
      step();
    end
    checks++;
    if (err_cnt !== 2'd3 || dut_vec !== exp_vec) begin errors++; $display("FAIL sat got %0d want 3", err_cnt); end
    clr_cnt = 1;
    set_in(1, 9'h000, 1, 1, 1, 1);
    step();
    clr_cnt = 0;
    checks++;
    if (err_cnt !== 2'd0 || dut_vec !== exp_vec) begin errors++; $display("FAIL clr_priority got %0d want 0", err_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    set_in(1, 9'h001, 0, 1, 1, 0);
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    checks++;
    if (out_valid !== 1'b0 || dut_vec !== exp_vec) begin errors++; $display("FAIL rst_mid got %h want %h", dut_vec, exp_vec); end
    set_in(1, 9'h003, 1, 1, 0, 1);
    step();
    checks++;
    if (out_data !== 9'h103 || out_frame_par !== 1'b1 || dut_vec !== exp_vec) begin
      errors++; $display("FAIL rst_fresh_mode got %h want %h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n   = ($urandom_range(0, 59) != 0);
      clr_cnt = ($urandom_range(0, 29) == 0);
      set_in($urandom_range(0, 3) != 0, 9'($urandom), $urandom_range(0, 2) == 0,
             1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      if (rst_n) begin
        checks++;
        if (in_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready[%0d] got %b want %b", i, in_ready, exp_rdy); end
      end
      step();
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL rand_out[%0d] got %h want %h", i, dut_vec, exp_vec); end
    end
    rst_n = 1; clr_cnt = 0;
  endtask

  initial begin
    test_reset();
    test_gen_odd();
    test_back_to_back();
    test_check_odd();
    test_backpressure();
    test_frame();
    test_saturation();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
